mc6809_dma_arbiter: RTL and testbench
=====================================

# mc6809_dma_arbiter

Shares the 6809 external bus between the CPU core and one DMA requester (cartridge loader, debug/save-state engine) using the CPU's nDMA/BREQ handshake. It requests the bus, waits for the core to float it (BA=1, BS=1), and runs single-word read/write transfers on E-falling strobes. It enforces a maximum burst so the CPU is never starved, then hands the bus back. It sits beside the CPU wrapper and drives the address/data mux select for the system bus.

## Interface
- MAX_BURST, 14: transfers per grant before forced release (6809 steal limit)
- GRANT_TIMEOUT, 16: fallE strobes to wait for grant before aborting
- MIN_GAP, 1: fallE strobes the bus stays with the CPU between grants
- CLK  in  1  system clock, the same clock as the CPU wrapper
- RESET  in  1  synchronous, active-high reset
- fallE  in  1  one-CLK strobe at E falling edge; all bus decisions are made here
- BA  in  1  CPU bus-available status
- BS  in  1  CPU bus-state status
- Din  in  8  system read data bus
- req  in  1  requester wants one transfer; held high with stable fields until ack
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  16  transfer address
- req_wdata  in  8  write data
- nDMA  out  1  to the CPU nDMA pin, active low
- bus_own  out  1  1 = the arbiter drives ADDR/RnW/Dout; system mux select
- ADDR  out  16  DMA address, valid when bus_own=1
- RnW  out  1  DMA read/write, valid when bus_own=1
- Dout  out  8  DMA write data
- ack  out  1  one-CLK pulse when a transfer completes
- rdata  out  8  read data, valid from the ack pulse until the next ack
- timeout  out  1  one-CLK pulse when a grant wait is aborted

## Operation
- States: IDLE, REQ, XFER, REL, GAP.
- IDLE: when req=1, go to REQ. nDMA drops to 0 on the next CLK.
- REQ: nDMA=0. On a fallE with BA=1 and BS=1, go to XFER and set bus_own=1.
  - On the GRANT_TIMEOUT-th fallE without a grant: pulse timeout and go to REL. No ack is issued; the requester keeps req asserted and retries.
- XFER: ADDR=req_addr, RnW=~req_wr and Dout=req_wdata, combinational from the inputs while bus_own=1.
  - A transfer completes on each fallE with req=1. ack pulses in that same CLK, and rdata<=Din on reads.
  - A burst counter (4 bits, 0..MAX_BURST) counts transfers. After MAX_BURST transfers, go to REL.
  - On a fallE with req=0, go to REL. No transfer takes place.
- REL: nDMA=1 and bus_own=0, both in the CLK of entry. On a fallE with BA=0, go to GAP.
- GAP: count MIN_GAP fallE strobes, then go to IDLE. A pending req is serviced from IDLE afterwards.
- When MRDY stalls the CPU, fallE stops. The arbiter simply holds its state; it never acts between strobes except for the IDLE->REQ transition.

## Timing
- Reset values: nDMA=1, bus_own=0, ack=0, timeout=0, rdata=0x00, ADDR=0x0000, RnW=1, Dout=0x00; state=IDLE, counters=0.
- Outputs that are not valid while bus_own=0: ADDR=0x0000, RnW=1, Dout=0x00.
- RESET mid-burst: on the next CLK, all outputs take their reset values and the burst counter clears. No ack is issued for a transfer in flight.
- Latency is counted from req rising in IDLE:
  - nDMA=0 after 1 CLK.
  - The grant strobe is the first fallE where the CPU reports BA=BS=1 (3 E-cycles on a real 6809).
  - The first ack is on the next fallE after the grant strobe.
- req and ack in the same CLK as a fallE:
  - If req falls in the same CLK that ack pulses, nothing happens.
  - A req still high on the next fallE is a new transfer.
- Burst counter: saturating arithmetic, compared with == MAX_BURST; it never wraps. It clears when entering REQ.
- Simultaneous events on one fallE: the MAX_BURST release and a still-high req give release, and req waits for the next grant. Timeout and grant on the same fallE give grant.

## Structure
- Shared package mc6809_bus_pkg holds:
  - the state enum (IDLE, REQ, XFER, REL, GAP);
  - the default constants MAX_BURST=14, GRANT_TIMEOUT=16, MIN_GAP=1.
- Single module with no sub-modules. The counters are small enough to stay inline.

## Test plan
- Single read: CPU model grants after 3 fallE, req_addr=0xC800, Din=0x5A -> nDMA low 1 CLK after req; one ack on the fallE after the grant; rdata=0x5A; release, then nDMA=1.
- Long burst: req held high for 20 writes -> exactly 14 acks, then nDMA=1 and bus_own=0; after BA=0 plus 1 gap strobe, nDMA drops again; the remaining 6 acks follow.
- Grant timeout: BA held 0 -> a timeout pulse on the 16th fallE, nDMA returns to 1, no ack.
- RESET asserted in XFER after 5 transfers -> next CLK: nDMA=1, bus_own=0, ADDR=0x0000, no ack; a fresh req gives a normal grant afterwards.
- MRDY stall: fallE suppressed for 10 CLK mid-burst -> state, outputs and count unchanged; the burst resumes with no lost or duplicated ack.
- req dropped after 3 transfers -> release on the next fallE with exactly 3 acks; GAP is honoured before any new nDMA assertion.

Source files
------------

// File: rtl/mc6809_bus_pkg.sv
// Shared constants and state type for the 6809 bus DMA arbiter.
package mc6809_bus_pkg;

    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned DATA_W        = 8;

    // Transfers per grant before the bus is forcibly handed back to the CPU.
    localparam int unsigned MAX_BURST     = 14;
    // fallE strobes to wait for BA/BS before abandoning a grant request.
    localparam int unsigned GRANT_TIMEOUT = 16;
    // fallE strobes the CPU keeps the bus between two grants.
    localparam int unsigned MIN_GAP       = 1;

    localparam int unsigned BURST_W       = 4;
    localparam int unsigned TMO_W         = 5;
    localparam int unsigned GAP_W         = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        XFER = 3'd2,
        REL  = 3'd3,
        GAP  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/mc6809_dma_arbiter.sv
// Shares the 6809 external bus between the CPU and one DMA requester via nDMA/BREQ.
module mc6809_dma_arbiter
    import mc6809_bus_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              fallE,
    input  logic              BA,
    input  logic              BS,
    input  logic [DATA_W-1:0] Din,
    input  logic              req,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              nDMA,
    output logic              bus_own,
    output logic [ADDR_W-1:0] ADDR,
    output logic              RnW,
    output logic [DATA_W-1:0] Dout,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              timeout
);

    arb_state_e          state_q,   state_d;
    logic [BURST_W-1:0]  burst_q,   burst_d;
    logic [TMO_W-1:0]    tmo_q,     tmo_d;
    logic [GAP_W-1:0]    gap_q,     gap_d;
    logic                ndma_q,    ndma_d;
    logic                bus_own_q, bus_own_d;
    logic                ack_q,     ack_d;
    logic                timeout_q, timeout_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic [BURST_W-1:0]  burst_inc;

    // State register and registered outputs; synchronous reset to the idle, CPU-owned bus.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            burst_q   <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            ndma_q    <= 1'b1;
            bus_own_q <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            ndma_q    <= ndma_d;
            bus_own_q <= bus_own_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state logic; apart from IDLE->REQ every decision waits for a fallE strobe.
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        ndma_d    = ndma_q;
        bus_own_d = bus_own_q;
        ack_d     = 1'b0;
        timeout_d = 1'b0;
        rdata_d   = rdata_q;
        // Saturating so a stray extra strobe can never wrap past the limit.
        burst_inc = (burst_q == BURST_W'(MAX_BURST)) ? burst_q : burst_q + BURST_W'(1);

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = REQ;
                    ndma_d  = 1'b0;
                    burst_d = '0;
                    tmo_d   = '0;
                end
            end

            REQ: begin
                if (fallE) begin
                    // A grant on the same strobe as the timeout wins.
                    if (BA && BS) begin
                        state_d   = XFER;
                        bus_own_d = 1'b1;
                    end else if (tmo_q == TMO_W'(GRANT_TIMEOUT - 1)) begin
                        state_d   = REL;
                        ndma_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end

            XFER: begin
                if (fallE) begin
                    if (req) begin
                        ack_d   = 1'b1;
                        burst_d = burst_inc;
                        if (!req_wr) begin
                            rdata_d = Din;
                        end
                        // Burst limit releases even with req still high; it waits for the next grant.
                        if (burst_inc == BURST_W'(MAX_BURST)) begin
                            state_d   = REL;
                            ndma_d    = 1'b1;
                            bus_own_d = 1'b0;
                        end
                    end else begin
                        state_d   = REL;
                        ndma_d    = 1'b1;
                        bus_own_d = 1'b0;
                    end
                end
            end

            REL: begin
                if (fallE && !BA) begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end

            GAP: begin
                if (fallE) begin
                    if (gap_q == GAP_W'(MIN_GAP - 1)) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                ndma_d    = 1'b1;
                bus_own_d = 1'b0;
            end
        endcase
    end

    assign nDMA    = ndma_q;
    assign bus_own = bus_own_q;
    assign ack     = ack_q;
    assign timeout = timeout_q;
    assign rdata   = rdata_q;

    // Bus-side fields follow the requester directly while we own the bus, idle values otherwise.
    assign ADDR = bus_own_q ? req_addr  : '0;
    assign RnW  = bus_own_q ? ~req_wr   : 1'b1;
    assign Dout = bus_own_q ? req_wdata : '0;

endmodule

// File: tb/tb_mc6809_dma_arbiter.sv
// Directed scoreboard bench for mc6809_dma_arbiter with a small 6809 BA/BS model.
module tb_mc6809_dma_arbiter;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } xfer_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        fallE = 1'b0;
    logic        BA = 1'b0;
    logic        BS = 1'b0;
    logic        req, req_wr;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        nDMA, bus_own, RnW, ack, timeout;
    logic [15:0] ADDR;
    logic [7:0]  Dout, rdata;
    wire  [7:0]  Din;

    int          n_checks = 0;
    int          n_fail   = 0;
    xfer_t       sb[$];
    logic [7:0]  exp_rd = 8'h00;
    logic        stall = 1'b0;
    logic        cpu_block = 1'b0;
    logic [1:0]  phase = 2'd0;
    int          gcnt = 0;
    int          strobes = 0;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return (a == 16'hC800) ? 8'h5A : (a[7:0] ^ a[15:8] ^ 8'h3C);
    endfunction

    assign Din = mem(ADDR);

    mc6809_dma_arbiter dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .fallE     (fallE),
        .BA        (BA),
        .BS        (BS),
        .Din       (Din),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .nDMA      (nDMA),
        .bus_own   (bus_own),
        .ADDR      (ADDR),
        .RnW       (RnW),
        .Dout      (Dout),
        .ack       (ack),
        .rdata     (rdata),
        .timeout   (timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count fallE strobes the DUT actually samples.
    always @(posedge CLK) begin
        if (fallE) strobes <= strobes + 1;
    end

    // E-strobe generator, CPU BA/BS model and scoreboard checker.
    always @(negedge CLK) begin
        if (ack) begin
            check("ack_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                if (!sb[0].wr) exp_rd = mem(sb[0].addr);
                void'(sb.pop_front());
            end
            check("rdata", 32'(rdata), 32'(exp_rd));
        end
        if (fallE) begin
            if (nDMA) begin
                BA   = 1'b0;
                BS   = 1'b0;
                gcnt = 0;
            end else if (!BA && !cpu_block) begin
                if (gcnt == 2) begin
                    BA   = 1'b1;
                    BS   = 1'b1;
                    gcnt = 0;
                end else begin
                    gcnt++;
                end
            end
        end
        fallE = (phase == 2'd3) && !stall;
        phase = phase + 2'd1;
        if (fallE && bus_own && req && sb.size() != 0) begin
            check("bus_addr", 32'(ADDR), 32'(sb[0].addr));
            check("bus_rnw",  32'(RnW),  32'(!sb[0].wr));
            check("bus_dout", 32'(Dout), 32'(sb[0].wdata));
        end
    end

    task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] d);
        req       = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        sb.push_back('{wr: wr, addr: a, wdata: d});
    endtask

    task automatic wait_ack(input string tag, output int n, output int k_own);
        n = 0;
        k_own = -1;
        do begin
            @(negedge CLK);
            n++;
            if (bus_own === 1'b1 && k_own < 0) k_own = n;
        end while (ack !== 1'b1 && n < 400);
        check(tag, 32'(ack), 32'd1);
    endtask

    task automatic wait_ndma(input string tag, input logic val, output int n, output int na);
        n = 0;
        na = 0;
        do begin
            @(negedge CLK);
            n++;
            if (ack) na++;
        end while (nDMA !== val && n < 400);
        check(tag, 32'(nDMA), 32'(val));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, na, k, s0, a;
        RESET = 1'b1; req = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
        repeat (3) @(negedge CLK);
        check("rst_ndma",    32'(nDMA),    32'd1);
        check("rst_bus_own", 32'(bus_own), 32'd0);
        check("rst_ack",     32'(ack),     32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_rdata",   32'(rdata),   32'h00);
        check("rst_addr",    32'(ADDR),    32'h0000);
        check("rst_rnw",     32'(RnW),     32'd1);
        check("rst_dout",    32'(Dout),    32'h00);
        RESET = 1'b0;

        // Single read
        @(negedge CLK);
        issue(1'b0, 16'hC800, 8'h00);
        @(negedge CLK);
        check("rd_ndma_lat", 32'(nDMA), 32'd0);
        wait_ack("rd_ack", n, k);
        check("rd_ack_after_grant", 32'(n - k), 32'd4);
        req = 1'b0;
        wait_ndma("rd_release", 1'b1, n, na);
        check("rd_release_own", 32'(bus_own), 32'd0);
        check("rd_single_ack", 32'(na), 32'd0);

        // Long burst of 20 writes
        repeat (12) @(negedge CLK);
        issue(1'b1, 16'h4000, 8'h80);
        for (int i = 0; i < 20; i++) begin
            wait_ack("burst_ack", n, k);
            check("burst_own_at_ack", 32'(bus_own), (i == 13) ? 32'd0 : 32'd1);
            if (i < 19) issue(1'b1, 16'h4000 + 16'(i + 1), 8'h80 + 8'(i + 1));
            else req = 1'b0;
            if (i == 13) begin
                check("burst_ndma_rel", 32'(nDMA), 32'd1);
                wait_ndma("burst_regrant", 1'b0, n, na);
                check("burst_gap_clks", 32'(n), 32'd9);
                check("burst_no_ack_rel", 32'(na), 32'd0);
            end
        end
        wait_ndma("burst_end", 1'b1, n, na);
        check("burst_end_acks", 32'(na), 32'd0);

        // Grant timeout
        repeat (12) @(negedge CLK);
        @(posedge CLK);
        cpu_block = 1'b1;
        @(negedge CLK);
        req = 1'b1; req_wr = 1'b0; req_addr = 16'h1234; req_wdata = 8'h00;
        wait_ndma("to_req", 1'b0, n, na);
        s0 = strobes;
        n = 0; a = 0;
        do begin
            @(negedge CLK);
            n++;
            if (ack) a++;
        end while (!timeout && n < 400);
        check("to_pulse",   32'(timeout),     32'd1);
        check("to_strobes", 32'(strobes - s0), 32'd16);
        check("to_ndma",    32'(nDMA),        32'd1);
        check("to_no_ack",  32'(a),           32'd0);
        req = 1'b0;
        @(posedge CLK);
        cpu_block = 1'b0;

        // Reset after 5 transfers of a burst
        repeat (12) @(negedge CLK);
        issue(1'b0, 16'h2000, 8'h00);
        for (int i = 0; i < 5; i++) begin
            wait_ack("rst_burst_ack", n, k);
            issue(1'b0, 16'h2001 + 16'(i), 8'h00);
        end
        RESET = 1'b1;
        @(negedge CLK);
        check("midrst_ndma",    32'(nDMA),    32'd1);
        check("midrst_bus_own", 32'(bus_own), 32'd0);
        check("midrst_addr",    32'(ADDR),    32'h0000);
        check("midrst_ack",     32'(ack),     32'd0);
        check("midrst_rdata",   32'(rdata),   32'h00);
        RESET = 1'b0;
        req = 1'b0;
        sb.delete();
        exp_rd = 8'h00;
        repeat (12) @(negedge CLK);
        issue(1'b0, 16'hC800, 8'h00);
        wait_ack("post_rst_ack", n, k);
        req = 1'b0;
        wait_ndma("post_rst_rel", 1'b1, n, na);

        // MRDY stall mid-burst
        repeat (12) @(negedge CLK);
        issue(1'b0, 16'h3000, 8'h00);
        for (int i = 0; i < 6; i++) begin
            wait_ack("stall_ack", n, k);
            if (i < 5) issue(1'b0, 16'h3001 + 16'(i), 8'h00);
            else req = 1'b0;
            if (i == 2) begin
                s0 = strobes;
                a = 0;
                @(posedge CLK);
                stall = 1'b1;
                repeat (10) begin
                    @(negedge CLK);
                    if (ack) a++;
                end
                check("stall_no_ack",  32'(a),            32'd0);
                check("stall_strobes", 32'(strobes - s0), 32'd0);
                check("stall_ndma",    32'(nDMA),         32'd0);
                check("stall_own",     32'(bus_own),      32'd1);
                @(posedge CLK);
                stall = 1'b0;
            end
        end
        wait_ndma("stall_rel", 1'b1, n, na);
        check("stall_extra_ack", 32'(na), 32'd0);

        // Request dropped after 3 transfers, then gap before the next grant
        repeat (12) @(negedge CLK);
        issue(1'b1, 16'h5000, 8'h11);
        for (int i = 0; i < 3; i++) begin
            wait_ack("drop_ack", n, k);
            if (i < 2) issue(1'b1, 16'h5001 + 16'(i), 8'h12 + 8'(i));
            else req = 1'b0;
        end
        wait_ndma("drop_rel", 1'b1, n, na);
        check("drop_extra_ack", 32'(na), 32'd0);
        check("drop_own", 32'(bus_own), 32'd0);
        issue(1'b0, 16'h5055, 8'h00);
        wait_ndma("drop_regrant", 1'b0, n, na);
        check("drop_gap_clks", 32'(n), 32'd9);
        wait_ack("drop_new_ack", n, k);
        req = 1'b0;
        wait_ndma("drop_new_rel", 1'b1, n, na);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
